uart_rx_ctrl: RTL and testbench

//  Sequencer/configurator for the UART receive path. Owns the baud divisor and reset
//  of the RX datapath. Drains received bytes from the RX FIFO into a valid/ready stream.

---
 rtl/uart_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer and configurator for the UART receive path.
//   Owns the baud divisor and the reset of the RX datapath. Drains bytes from the
//   show-ahead RX FIFO into a valid/ready stream. When the line stays idle past a
//   programmable timeout, it marks the last byte of the frame.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cfg_we_i/baud_i/timeout_i  configuration write (baud change restarts the datapath)
//   baud_o, rx_rst_o           divisor and active-high reset to the RX datapath/FIFO
//   fifo_avail_i/dat_i/rd_o    RX FIFO status, head byte and pop strobe
//   m_dat_o/last_o/valid_o     registered output stream, m_ready_i back-pressure
//   busy_o                     controller not idle
// Optional feature macro UART_RX_CTRL_STATS_EN adds the stat_bytes_o/stat_frames_o
// counters (saturating, cleared by any config write).
module uart_rx_ctrl #(
   parameter int unsigned            BAUD_WORD       = 16,
   parameter int unsigned            TIMEOUT_W       = 8,
   parameter logic [BAUD_WORD-1:0]   DEFAULT_BAUD    = BAUD_WORD'(434),
   parameter logic [TIMEOUT_W-1:0]   DEFAULT_TIMEOUT = TIMEOUT_W'(200)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_we_i,
   input  logic [BAUD_WORD-1:0] cfg_baud_i,
   input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
   output logic [BAUD_WORD-1:0] baud_o,
   output logic                 rx_rst_o,
   input  logic                 fifo_avail_i,
   input  logic [7:0]           fifo_dat_i,
   output logic                 fifo_rd_o,
   output logic [7:0]           m_dat_o,
   output logic                 m_last_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
`ifdef UART_RX_CTRL_STATS_EN
   output logic [15:0]          stat_bytes_o,
   output logic [15:0]          stat_frames_o,
`endif
   output logic                 busy_o
);

   typedef enum logic [1:0] {StRcfg, StIdle, StPend, StOut} state_e;

   state_e               state_q, state_d;
   logic                 rcfg_cnt_q, rcfg_cnt_d;
   logic [BAUD_WORD-1:0] baud_q, baud_d;
   logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
   logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [7:0]           m_dat_q, m_dat_d;
   logic                 m_last_q, m_last_d;
   logic                 m_valid_q, m_valid_d;
   logic                 baud_chg;
   logic                 hs;

   assign baud_chg = cfg_we_i && (cfg_baud_i != baud_q);
   assign hs       = m_valid_q && m_ready_i;

   always_comb begin
      state_d    = state_q;
      rcfg_cnt_d = rcfg_cnt_q;
      baud_d     = baud_q;
      timeout_d  = timeout_q;
      idle_cnt_d = idle_cnt_q;
      m_dat_d    = m_dat_q;
      m_last_d   = m_last_q;
      m_valid_d  = m_valid_q;
      fifo_rd_o  = 1'b0;
      rx_rst_o   = 1'b0;

      unique case (state_q)
         StRcfg: begin
            rx_rst_o = 1'b1;
            if (rcfg_cnt_q) begin
               state_d = StIdle;
            end else begin
               rcfg_cnt_d = 1'b1;
            end
         end
         StIdle: begin
            if (fifo_avail_i) begin
               fifo_rd_o  = 1'b1;
               m_dat_d    = fifo_dat_i;
               idle_cnt_d = '0;
               state_d    = StPend;
            end
         end
         StPend: begin
            // A following byte proves the frame continues; offer without waiting.
            if (fifo_avail_i) begin
               m_last_d  = 1'b0;
               m_valid_d = 1'b1;
               state_d   = StOut;
            // >= rather than == so a timeout lowered mid-count still terminates.
            end else if (idle_cnt_q >= timeout_q) begin
               m_last_d  = 1'b1;
               m_valid_d = 1'b1;
               state_d   = StOut;
            end else if (idle_cnt_q != '1) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         StOut: begin
            if (hs) begin
               m_valid_d = 1'b0;
               if (!m_last_q && fifo_avail_i) begin
                  fifo_rd_o  = 1'b1;
                  m_dat_d    = fifo_dat_i;
                  idle_cnt_d = '0;
                  state_d    = StPend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StRcfg;
      endcase

      if (cfg_we_i) begin
         timeout_d = cfg_timeout_i;
      end

      // A new divisor invalidates anything in flight: drop the held byte, skip the
      // pop and restart the datapath reset sequence.
      if (baud_chg) begin
         baud_d     = cfg_baud_i;
         fifo_rd_o  = 1'b0;
         m_dat_d    = m_dat_q;
         m_valid_d  = 1'b0;
         rcfg_cnt_d = 1'b0;
         state_d    = StRcfg;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StRcfg;
         rcfg_cnt_q <= 1'b0;
         baud_q     <= DEFAULT_BAUD;
         timeout_q  <= DEFAULT_TIMEOUT;
         idle_cnt_q <= '0;
         m_dat_q    <= 8'h00;
         m_last_q   <= 1'b0;
         m_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rcfg_cnt_q <= rcfg_cnt_d;
         baud_q     <= baud_d;
         timeout_q  <= timeout_d;
         idle_cnt_q <= idle_cnt_d;
         m_dat_q    <= m_dat_d;
         m_last_q   <= m_last_d;
         m_valid_q  <= m_valid_d;
      end
   end

   assign baud_o    = baud_q;
   assign m_dat_o   = m_dat_q;
   assign m_last_o  = m_last_q;
   assign m_valid_o = m_valid_q;
   assign busy_o    = (state_q != StIdle);

`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] bytes_q, bytes_d;
   logic [15:0] frames_q, frames_d;

   always_comb begin
      bytes_d  = bytes_q;
      frames_d = frames_q;
      if (cfg_we_i) begin
         bytes_d  = '0;
         frames_d = '0;
      end else if (hs) begin
         if (bytes_q != 16'hFFFF) begin
            bytes_d = bytes_q + 16'd1;
         end
         if (m_last_q && (frames_q != 16'hFFFF)) begin
            frames_d = frames_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bytes_q  <= '0;
         frames_q <= '0;
      end else begin
         bytes_q  <= bytes_d;
         frames_q <= frames_d;
      end
   end

   assign stat_bytes_o  = bytes_q;
   assign stat_frames_o = frames_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: a queue-based FIFO model feeds the DUT, a scoreboard
// queue holds expected {last, data} beats and a monitor process checks each handshake.
module tb_uart_rx_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [15:0] cfg_baud_i = 16'd434;
   logic [7:0]  cfg_timeout_i = 8'd200;
   logic [15:0] baud_o;
   logic        rx_rst_o;
   logic        fifo_avail_i = 1'b0;
   logic [7:0]  fifo_dat_i = 8'h00;
   logic        fifo_rd_o;
   logic [7:0]  m_dat_o;
   logic        m_last_o;
   logic        m_valid_o;
   logic        m_ready_i = 1'b0;
   logic        busy_o;
`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] stat_bytes_o;
   logic [15:0] stat_frames_o;
`endif

   uart_rx_ctrl dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .cfg_we_i      (cfg_we_i),
      .cfg_baud_i    (cfg_baud_i),
      .cfg_timeout_i (cfg_timeout_i),
      .baud_o        (baud_o),
      .rx_rst_o      (rx_rst_o),
      .fifo_avail_i  (fifo_avail_i),
      .fifo_dat_i    (fifo_dat_i),
      .fifo_rd_o     (fifo_rd_o),
      .m_dat_o       (m_dat_o),
      .m_last_o      (m_last_o),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
`ifdef UART_RX_CTRL_STATS_EN
      .stat_bytes_o  (stat_bytes_o),
      .stat_frames_o (stat_frames_o),
`endif
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc_n = 0;
   int          rd_cnt = 0;
   int          rd_cyc = 0;
   int          hs_cyc = 0;
   logic        rd_seen = 1'b0;
   logic [7:0]  fq[$];
   logic [8:0]  sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fifo_update();
      fifo_avail_i = (fq.size() != 0);
      fifo_dat_i   = (fq.size() != 0) ? fq[0] : 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic last, input logic expect_it);
      fq.push_back(d);
      if (expect_it) sb_q.push_back({last, d});
      fifo_update();
   endtask

   // Sample half-cycle: inputs are stable, look at the combinational pop strobe.
   task automatic sample();
      @(negedge clk_i);
      rd_seen = fifo_rd_o;
      if (rd_seen) begin
         rd_cnt++;
         rd_cyc = cyc_n;
         check("rd_needs_avail", {31'd0, fifo_avail_i}, 32'd1);
         check("rd_not_in_rcfg", {31'd0, rx_rst_o}, 32'd0);
      end
   endtask

   // Active edge, then apply the pop the DUT requested and let stimulus move on.
   task automatic adv();
      @(posedge clk_i);
      #1;
      cyc_n++;
      if (rd_seen && fq.size() != 0) void'(fq.pop_front());
      rd_seen = 1'b0;
      fifo_update();
   endtask

   task automatic cyc();
      sample();
      adv();
   endtask

   task automatic cfg_write(input logic [15:0] baud, input logic [7:0] tmo);
      cfg_we_i      = 1'b1;
      cfg_baud_i    = baud;
      cfg_timeout_i = tmo;
      cyc();
      cfg_we_i = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sample();
         if (m_valid_o) begin
            ok = 1'b1;
            break;
         end
         adv();
      end
      check(name, {31'd0, ok}, 32'd1);
      if (ok) adv();
   endtask

   task automatic drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         sample();
         if (sb_q.size() == 0 && fq.size() == 0 && !busy_o) begin
            ok = 1'b1;
            adv();
            break;
         end
         adv();
      end
      check(name, {31'd0, ok}, 32'd1);
   endtask

   // Monitor: every handshake must match the head of the scoreboard.
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_i);
         if (rst_ni && m_valid_o && m_ready_i) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %02h with no expected beat", m_dat_o);
            end else begin
               e = sb_q.pop_front();
               check("beat_dat", {24'd0, m_dat_o}, {24'd0, e[7:0]});
               check("beat_last", {31'd0, m_last_o}, {31'd0, e[8]});
            end
            hs_cyc = cyc_n;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_base;

      // Reset values while held in reset.
      sample();
      check("rst_rx_rst", {31'd0, rx_rst_o}, 32'd1);
      check("rst_baud", {16'd0, baud_o}, 32'd434);
      check("rst_rd", {31'd0, fifo_rd_o}, 32'd0);
      check("rst_valid", {31'd0, m_valid_o}, 32'd0);
      check("rst_last", {31'd0, m_last_o}, 32'd0);
      check("rst_dat", {24'd0, m_dat_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd1);
      adv();
      rst_ni = 1'b1;
      sample();
      check("rcfg_c1", {31'd0, rx_rst_o}, 32'd1);
      adv();
      sample();
      check("rcfg_c2", {31'd0, rx_rst_o}, 32'd1);
      adv();
      sample();
      check("rcfg_c3_rx_rst", {31'd0, rx_rst_o}, 32'd0);
      check("rcfg_c3_busy", {31'd0, busy_o}, 32'd0);
      check("rcfg_c3_baud", {16'd0, baud_o}, 32'd434);
      adv();

      // Two back-to-back bytes, timeout 5 (same baud: no datapath reset).
      cfg_write(16'd434, 8'd5);
      sample();
      check("same_baud_no_rst", {31'd0, rx_rst_o}, 32'd0);
      adv();
      m_ready_i = 1'b1;
      rd_base = rd_cnt;
      push_byte(8'h41, 1'b0, 1'b1);
      push_byte(8'h42, 1'b1, 1'b1);
      drain("drain_4142");
      check("rd_pulses_4142", rd_cnt - rd_base, 32'd2);
      check("timeout5_latency", hs_cyc - rd_cyc, 32'd7);

      // Back-pressure: 0x55 held stable for 10 cycles, no extra pop.
      m_ready_i = 1'b0;
      push_byte(8'h55, 1'b0, 1'b1);
      push_byte(8'h56, 1'b1, 1'b1);
      wait_valid("valid_55");
      rd_base = rd_cnt;
      for (int i = 0; i < 10; i++) begin
         sample();
         check("stall_valid", {31'd0, m_valid_o}, 32'd1);
         check("stall_dat", {24'd0, m_dat_o}, 32'h55);
         check("stall_last", {31'd0, m_last_o}, 32'd0);
         adv();
      end
      check("stall_no_pop", rd_cnt - rd_base, 32'd0);
      m_ready_i = 1'b1;
      drain("drain_5556");

      // Baud change while offering 0x60: byte discarded, 0x61 stays queued.
      m_ready_i = 1'b0;
      push_byte(8'h60, 1'b0, 1'b0);
      push_byte(8'h61, 1'b1, 1'b1);
      wait_valid("valid_60");
      rd_base = rd_cnt;
      cfg_write(16'd217, 8'd5);
      sample();
      check("chg_valid_drop", {31'd0, m_valid_o}, 32'd0);
      check("chg_baud", {16'd0, baud_o}, 32'd217);
      check("chg_rx_rst_c1", {31'd0, rx_rst_o}, 32'd1);
      adv();
      sample();
      check("chg_rx_rst_c2", {31'd0, rx_rst_o}, 32'd1);
      check("chg_no_pop", rd_cnt - rd_base, 32'd0);
      adv();
      sample();
      check("chg_rx_rst_c3", {31'd0, rx_rst_o}, 32'd0);
      check("chg_busy_c3", {31'd0, busy_o}, 32'd0);
      adv();
      m_ready_i = 1'b1;
      drain("drain_61");

      // Same-value write mid-stream leaves the stream alone.
      push_byte(8'h70, 1'b0, 1'b1);
      push_byte(8'h71, 1'b1, 1'b1);
      cyc();
      cfg_write(16'd217, 8'd5);
      sample();
      check("same_mid_no_rst", {31'd0, rx_rst_o}, 32'd0);
      check("same_mid_baud", {16'd0, baud_o}, 32'd217);
      adv();
      drain("drain_7071");

      // Timeout 0: single byte offered with last=1 two cycles after its pop.
      cfg_write(16'd217, 8'd0);
      push_byte(8'h7E, 1'b1, 1'b1);
      drain("drain_7e");
      check("timeout0_latency", hs_cyc - rd_cyc, 32'd2);

`ifdef UART_RX_CTRL_STATS_EN
      cfg_write(16'd217, 8'd0);
      sample();
      check("stat_clr_bytes", {16'd0, stat_bytes_o}, 32'd0);
      adv();
      push_byte(8'h01, 1'b0, 1'b1);
      push_byte(8'h02, 1'b0, 1'b1);
      push_byte(8'h03, 1'b1, 1'b1);
      drain("drain_stats");
      sample();
      check("stat_bytes", {16'd0, stat_bytes_o}, 32'd3);
      check("stat_frames", {16'd0, stat_frames_o}, 32'd1);
      adv();
      cfg_write(16'd217, 8'd0);
      sample();
      check("stat_bytes_clr", {16'd0, stat_bytes_o}, 32'd0);
      check("stat_frames_clr", {16'd0, stat_frames_o}, 32'd0);
      adv();
`endif

      // Reset returns the configuration to defaults.
      rst_ni = 1'b0;
      sample();
      check("rst2_baud", {16'd0, baud_o}, 32'd434);
      check("rst2_rx_rst", {31'd0, rx_rst_o}, 32'd1);
      check("rst2_valid", {31'd0, m_valid_o}, 32'd0);
      adv();
      check("sb_empty", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
